bcd_display_feeder: RTL and testbench



---
 rtl/bcd_display_feeder_pkg.sv | 28 ++
 rtl/bcd_display_feeder_if.sv | 28 ++
 rtl/bcd_display_feeder_dabble_step.sv | 29 ++
 rtl/bcd_display_feeder.sv | 123 ++++++++++++
 tb/tb_bcd_display_feeder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_display_feeder_pkg.sv
// rtl/bcd_display_feeder_pkg.sv - shared constants, state encoding and blanking helper
package bcd_display_feeder_pkg;

  localparam int DISP_DIGITS = 8;
  localparam int BCD_W = DISP_DIGITS * 4;
  localparam logic [26:0] BCD_MAX = 27'd99_999_999;
  localparam logic [BCD_W-1:0] OVF_PATTERN = 32'hEEEE_EEEE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digit i (i >= 1) goes dark when it and every more significant digit are zero.
  function automatic logic [DISP_DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] b);
    logic [DISP_DIGITS-1:0] m;
    logic all_zero;
    m = '0;
    all_zero = 1'b1;
    for (int i = DISP_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (b[4*i +: 4] == 4'd0);
      m[i] = all_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_display_feeder_if.sv
// rtl/bcd_display_feeder_if.sv - request/result bundle between a value source and the display feeder
interface bcd_display_feeder_if
  import bcd_display_feeder_pkg::*;
#(
  parameter int BIN_W = 27
);

  logic                   start;
  logic [BIN_W-1:0]       bin;
  logic [DISP_DIGITS-1:0] dp;
  logic                   busy;
  logic                   done;
  logic [BCD_W-1:0]       nums;
  logic [DISP_DIGITS-1:0] ens;
  logic [DISP_DIGITS-1:0] points;
  logic                   overflow;

  modport master (
    output start, bin, dp,
    input  busy, done, nums, ens, points, overflow
  );

  modport slave (
    input  start, bin, dp,
    output busy, done, nums, ens, points, overflow
  );

endinterface

// File: rtl/bcd_display_feeder_dabble_step.sv
// rtl/bcd_display_feeder_dabble_step.sv - one double-dabble iteration: add-3 on every nibble >= 5, then shift {bcd, sr} left
module bcd_dabble_step
  import bcd_display_feeder_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input  logic [BCD_W-1:0] bcd_in,
  input  logic [BIN_W-1:0] sr_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic [BIN_W-1:0] sr_out
);

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] shifted;

  always_comb begin
    adj = bcd_in;
    for (int i = 0; i < DISP_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj, sr_in} << 1;
  end

  assign bcd_out = shifted[BIN_W +: BCD_W];
  assign sr_out  = shifted[BIN_W-1:0];

endmodule

// File: rtl/bcd_display_feeder.sv
// rtl/bcd_display_feeder.sv - sequential binary-to-BCD feeder for the 8-digit serial seven-segment wrapper
// Optional leading-zero blanking of the digit enables: LEADING_ZERO_BLANK_EN.
module bcd_display_feeder
  import bcd_display_feeder_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_display_feeder_if.slave   bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [DISP_DIGITS-1:0] ENS_IDLE = {{(DISP_DIGITS-1){1'b1}}, 1'b0};
`else
  localparam logic [DISP_DIGITS-1:0] ENS_IDLE = '0;
`endif

  state_t                 state;
  state_t                 state_next;
  logic                   accept;
  logic                   load_result;

  logic [BIN_W-1:0]       sr;
  logic [BIN_W-1:0]       sr_step;
  logic [BCD_W-1:0]       bcd;
  logic [BCD_W-1:0]       bcd_step;
  logic [CNT_W-1:0]       cnt;
  logic [DISP_DIGITS-1:0] dp_q;
  logic                   ovf_q;

  logic [BCD_W-1:0]       nums_q;
  logic [DISP_DIGITS-1:0] ens_q;
  logic [DISP_DIGITS-1:0] points_q;
  logic                   overflow_q;
  logic [DISP_DIGITS-1:0] result_ens;

  bcd_dabble_step #(
    .BIN_W (BIN_W)
  ) u_step (
    .bcd_in  (bcd),
    .sr_in   (sr),
    .bcd_out (bcd_step),
    .sr_out  (sr_step)
  );

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Results are captured on the final iteration so they are valid during the done pulse.
        if (cnt == CNT_W'(1)) begin
          load_result = 1'b1;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    result_ens = '0;
`ifdef LEADING_ZERO_BLANK_EN
    if (!ovf_q) begin
      result_ens = blank_mask(bcd_step);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      bcd        <= '0;
      cnt        <= '0;
      dp_q       <= '0;
      ovf_q      <= 1'b0;
      nums_q     <= '0;
      ens_q      <= ENS_IDLE;
      points_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        sr    <= bus.bin;
        dp_q  <= bus.dp;
        ovf_q <= (27'(bus.bin) > BCD_MAX);
        bcd   <= '0;
        cnt   <= CNT_W'(BIN_W);
      end else if (state == SHIFT) begin
        sr  <= sr_step;
        bcd <= bcd_step;
        cnt <= cnt - CNT_W'(1);
      end
      // Display-facing registers change only here, never mid-conversion.
      if (load_result) begin
        nums_q     <= ovf_q ? OVF_PATTERN : bcd_step;
        ens_q      <= result_ens;
        points_q   <= dp_q;
        overflow_q <= ovf_q;
      end
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.nums     = nums_q;
  assign bus.ens      = ens_q;
  assign bus.points   = points_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bcd_display_feeder.sv
// tb/tb_bcd_display_feeder.sv - directed vector bench for bcd_display_feeder
module tb_bcd_display_feeder;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam int W = 27;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bcd_display_feeder_if #(.BIN_W(W)) bus ();

  bcd_display_feeder #(.BIN_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] bin;
    logic [7:0]  dp;
    logic [31:0] nums;
    logic [7:0]  ens_blank;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_conv(input logic [26:0] b, input logic [7:0] d,
                          output int busy_cnt, output int done_idx, output bit stable);
    logic [31:0] prev;
    prev     = bus.nums;
    busy_cnt = 0;
    done_idx = 0;
    stable   = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = b;
    bus.dp    = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = ~b;
    bus.dp    = ~d;
    for (int i = 1; i <= 60; i++) begin
      if (bus.done) begin
        done_idx = i;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (bus.nums !== prev) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int busy_cnt;
    int done_idx;
    bit stable;
    int dones;
    int busy_tot;
    int first_done;
    int second_done;
    logic [31:0] nums_at_done;
    logic [7:0]  pts_at_done;

    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    bus.dp    = '0;

    vecs[0] = '{27'd0,           8'h00, 32'h0000_0000, 8'hFE, 1'b0};
    vecs[1] = '{27'd12_345_678,  8'h04, 32'h1234_5678, 8'h00, 1'b0};
    vecs[2] = '{27'd99_999_999,  8'h81, 32'h9999_9999, 8'h00, 1'b0};
    vecs[3] = '{27'd100_000_000, 8'h3C, 32'hEEEE_EEEE, 8'h00, 1'b1};
    vecs[4] = '{27'd305,         8'hA5, 32'h0000_0305, 8'hF8, 1'b0};
    vecs[5] = '{27'd134_217_727, 8'hFF, 32'hEEEE_EEEE, 8'h00, 1'b1};
    vecs[6] = '{27'd7,           8'h01, 32'h0000_0007, 8'hFE, 1'b0};
    vecs[7] = '{27'd10_000_000,  8'h80, 32'h1000_0000, 8'h00, 1'b0};
    vecs[8] = '{27'd4096,        8'h10, 32'h0000_4096, 8'hF0, 1'b0};
    vecs[9] = '{27'd90_000_009,  8'h00, 32'h9000_0009, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_nums", bus.nums, 32'h0);
    check("reset_points", 32'(bus.points), 32'h0);
    check("reset_ens", 32'(bus.ens), BLANK ? 32'hFE : 32'h00);
    check("reset_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      run_conv(vecs[v].bin, vecs[v].dp, busy_cnt, done_idx, stable);
      check($sformatf("v%0d_done_cycle", v), 32'(done_idx), 32'd28);
      check($sformatf("v%0d_busy_cycles", v), 32'(busy_cnt), 32'd27);
      check($sformatf("v%0d_nums_stable", v), 32'(stable), 32'd1);
      check($sformatf("v%0d_nums", v), bus.nums, vecs[v].nums);
      check($sformatf("v%0d_ens", v), 32'(bus.ens), BLANK ? 32'(vecs[v].ens_blank) : 32'h00);
      check($sformatf("v%0d_points", v), 32'(bus.points), 32'(vecs[v].dp));
      check($sformatf("v%0d_ovf", v), 32'(bus.overflow), 32'(vecs[v].ovf));
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", v), 32'(bus.done), 32'd0);
    end

    // A start pulse mid-conversion must be dropped, not queued.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 27'd1234;
    bus.dp    = 8'h11;
    @(negedge clk);
    bus.start    = 1'b0;
    dones        = 0;
    busy_tot     = 0;
    nums_at_done = '0;
    pts_at_done  = '0;
    for (int i = 1; i <= 45; i++) begin
      if (bus.done) begin
        dones++;
        nums_at_done = bus.nums;
        pts_at_done  = bus.points;
      end
      if (bus.busy) busy_tot++;
      if (i == 10) begin
        bus.start = 1'b1;
        bus.bin   = 27'd9999;
        bus.dp    = 8'hFF;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("ign_done_count", 32'(dones), 32'd1);
    check("ign_busy_total", 32'(busy_tot), 32'd27);
    check("ign_nums", nums_at_done, 32'h0000_1234);
    check("ign_points", 32'(pts_at_done), 32'h11);

    // Reset in the middle of SHIFT discards the conversion.
    bus.start = 1'b1;
    bus.bin   = 27'd555;
    bus.dp    = 8'h0F;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_done", 32'(bus.done), 32'd0);
    check("rstmid_nums", bus.nums, 32'h0);
    check("rstmid_points", 32'(bus.points), 32'h0);
    check("rstmid_ens", 32'(bus.ens), BLANK ? 32'hFE : 32'h00);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) dones++;
      @(negedge clk);
    end
    check("rstmid_no_activity", 32'(dones), 32'd0);
    run_conv(27'd87_654_321, 8'h42, busy_cnt, done_idx, stable);
    check("post_rst_done_cycle", 32'(done_idx), 32'd28);
    check("post_rst_nums", bus.nums, 32'h8765_4321);
    check("post_rst_points", 32'(bus.points), 32'h42);

    // Start held high gives back-to-back conversions.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.bin     = 27'd42;
    bus.dp      = 8'h00;
    first_done  = 0;
    second_done = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first_done == 0) first_done = i;
        else begin
          second_done = i;
          bus.start = 1'b0;
          break;
        end
      end
    end
    check("b2b_period", 32'(second_done - first_done), 32'(W + 2));
    check("b2b_nums", bus.nums, 32'h0000_0042);
    check("b2b_ens", 32'(bus.ens), BLANK ? 32'hFC : 32'h00);
    repeat (3) @(negedge clk);
    check("b2b_idle_after", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
